pipe_ctrl_unit: RTL and testbench

//  Pipelined successor to the single-cycle controller. Decodes the D-stage opcode/ALU-op into a control word.

---
 rtl/pipe_ctrl_unit_pkg.sv | 45 ++++
 rtl/pipe_ctrl_unit_decode.sv | 92 +++++++++
 rtl/pipe_ctrl_unit.sv | 205 ++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared definitions for the pipelined controller and its decoder:
// opcode and ALU-op encodings, write-back mux select codes, rstatus codes
// and the mult/div stall FSM state type.
package pipe_ctrl_unit_pkg;

  // Opcodes
  localparam logic [4:0] OPC_R    = 5'b00000;
  localparam logic [4:0] OPC_J    = 5'b00001;
  localparam logic [4:0] OPC_BNE  = 5'b00010;
  localparam logic [4:0] OPC_JAL  = 5'b00011;
  localparam logic [4:0] OPC_JR   = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_BLT  = 5'b00110;
  localparam logic [4:0] OPC_SW   = 5'b00111;
  localparam logic [4:0] OPC_LW   = 5'b01000;
  localparam logic [4:0] OPC_SETX = 5'b10101;
  localparam logic [4:0] OPC_BEX  = 5'b10110;

  // R-type ALU-op values the controller cares about
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  // Write-back mux select
  localparam logic [1:0] WB_SEL_ALU    = 2'd0;
  localparam logic [1:0] WB_SEL_MEM    = 2'd1;
  localparam logic [1:0] WB_SEL_PC1    = 2'd2;
  localparam logic [1:0] WB_SEL_STATUS = 2'd3;

  // rstatus codes
  localparam logic [2:0] STATUS_NONE = 3'd0;
  localparam logic [2:0] STATUS_ADD  = 3'd1;
  localparam logic [2:0] STATUS_ADDI = 3'd2;
  localparam logic [2:0] STATUS_SUB  = 3'd3;
  localparam logic [2:0] STATUS_MUL  = 3'd4;
  localparam logic [2:0] STATUS_DIV  = 3'd5;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// ctrl_decode: combinational opcode/alu_op -> control word.
// Shared with the single-cycle build.
// Ports:
//   d_valid     in   instruction present (0 = bubble)
//   opcode      in   opcode field
//   alu_op_in   in   ALU-op field
//   rd_in       in   rd field
//   alu_op      out  ALU operation (ADD unless R-type)
//   alu_imm     out  ALU B = immediate
//   ram_we      out  data-memory write enable
//   reg_we      out  regfile write enable
//   rd          out  write-back destination
//   wb_sel      out  write-back select
//   ovf_status  out  rstatus code if this instruction overflows (0 = overflow ignored)
//   md_status   out  rstatus code if this is mul/div (0 = not a mult/div op)
module ctrl_decode
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int OP_W       = 5,
  parameter int REG_W      = 5,
  parameter int STATUS_REG = 30,
  parameter int LINK_REG   = 31
) (
  input  logic             d_valid,
  input  logic [OP_W-1:0]  opcode,
  input  logic [OP_W-1:0]  alu_op_in,
  input  logic [REG_W-1:0] rd_in,
  output logic [OP_W-1:0]  alu_op,
  output logic             alu_imm,
  output logic             ram_we,
  output logic             reg_we,
  output logic [REG_W-1:0] rd,
  output logic [1:0]       wb_sel,
  output logic [2:0]       ovf_status,
  output logic [2:0]       md_status
);

  always_comb begin
    alu_op     = OP_W'(ALU_ADD);
    alu_imm    = 1'b0;
    ram_we     = 1'b0;
    reg_we     = 1'b0;
    rd         = '0;
    wb_sel     = WB_SEL_ALU;
    ovf_status = STATUS_NONE;
    md_status  = STATUS_NONE;
    if (d_valid) begin
      case (opcode)
        OP_W'(OPC_R): begin
          alu_op = alu_op_in;
          reg_we = 1'b1;
          rd     = rd_in;
          case (alu_op_in)
            OP_W'(ALU_ADD): ovf_status = STATUS_ADD;
            OP_W'(ALU_SUB): ovf_status = STATUS_SUB;
            OP_W'(ALU_MUL): md_status  = STATUS_MUL;
            OP_W'(ALU_DIV): md_status  = STATUS_DIV;
            default: ;
          endcase
        end
        OP_W'(OPC_JAL): begin
          reg_we = 1'b1;
          rd     = REG_W'(LINK_REG);
          wb_sel = WB_SEL_PC1;
        end
        OP_W'(OPC_ADDI): begin
          alu_imm    = 1'b1;
          reg_we     = 1'b1;
          rd         = rd_in;
          ovf_status = STATUS_ADDI;
        end
        OP_W'(OPC_SW): begin
          alu_imm = 1'b1;
          ram_we  = 1'b1;
        end
        OP_W'(OPC_LW): begin
          alu_imm = 1'b1;
          reg_we  = 1'b1;
          rd      = rd_in;
          wb_sel  = WB_SEL_MEM;
        end
        OP_W'(OPC_SETX): begin
          reg_we = 1'b1;
          rd     = REG_W'(STATUS_REG);
        end
        // j, bne, jr, blt, bex write nothing; undecoded opcodes are bubbles
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined controller. Decodes D into a control word and
// carries it through the X, M and W stage registers, with a mult/div stall
// FSM plus watchdog, overflow rerouting to rstatus, and branch flush.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   d_valid        D holds a real instruction
//   d_opcode       D-stage opcode
//   d_alu_op       D-stage ALU-op field
//   d_rd           D-stage rd
//   x_flush        taken branch resolved in X; kill D->X capture
//   x_alu_ovf      ALU overflow for the instruction in X
//   md_ready       mult/div result valid pulse
//   md_exc         mult/div exception, qualified by md_ready
//   stall          freeze PC, F/D and X
//   md_start       start pulse to mult/div unit
//   x_alu_op       ALU operation in X
//   x_alu_imm      ALU B = immediate
//   m_ram_we       data-memory write enable
//   w_reg_we       regfile write enable
//   w_rd           write-back destination
//   w_wb_sel       write-back select (ALU, MEM, PC+1, STATUS)
//   w_status       rstatus code
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int OP_W       = 5,
  parameter int REG_W      = 5,
  parameter int STATUS_REG = 30,
  parameter int LINK_REG   = 31,
  parameter int MD_TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [OP_W-1:0]  d_opcode,
  input  logic [OP_W-1:0]  d_alu_op,
  input  logic [REG_W-1:0] d_rd,
  input  logic             x_flush,
  input  logic             x_alu_ovf,
  input  logic             md_ready,
  input  logic             md_exc,
  output logic             stall,
  output logic             md_start,
  output logic [OP_W-1:0]  x_alu_op,
  output logic             x_alu_imm,
  output logic             m_ram_we,
  output logic             w_reg_we,
  output logic [REG_W-1:0] w_rd,
  output logic [1:0]       w_wb_sel,
  output logic [2:0]       w_status
);

  localparam int WD_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

  typedef struct packed {
    logic [OP_W-1:0]  alu_op;
    logic             alu_imm;
    logic             ram_we;
    logic             reg_we;
    logic [REG_W-1:0] rd;
    logic [1:0]       wb_sel;
    logic [2:0]       ovf_status;
    logic [2:0]       md_status;
  } x_word_t;

  typedef struct packed {
    logic             ram_we;
    logic             reg_we;
    logic [REG_W-1:0] rd;
    logic [1:0]       wb_sel;
    logic [2:0]       status;
  } m_word_t;

  typedef struct packed {
    logic             reg_we;
    logic [REG_W-1:0] rd;
    logic [1:0]       wb_sel;
    logic [2:0]       status;
  } w_word_t;

  x_word_t   x_dec, x_d, x_q;
  m_word_t   m_d, m_q;
  w_word_t   w_q;
  md_state_t state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic      exc_q, exc_d;

  ctrl_decode #(
    .OP_W       (OP_W),
    .REG_W      (REG_W),
    .STATUS_REG (STATUS_REG),
    .LINK_REG   (LINK_REG)
  ) u_decode (
    .d_valid    (d_valid),
    .opcode     (d_opcode),
    .alu_op_in  (d_alu_op),
    .rd_in      (d_rd),
    .alu_op     (x_dec.alu_op),
    .alu_imm    (x_dec.alu_imm),
    .ram_we     (x_dec.ram_we),
    .reg_we     (x_dec.reg_we),
    .rd         (x_dec.rd),
    .wb_sel     (x_dec.wb_sel),
    .ovf_status (x_dec.ovf_status),
    .md_status  (x_dec.md_status)
  );

  // Mult/div FSM. The op in X is started from IDLE; leaving DONE always
  // advances X, so a given instruction is never started twice.
  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    exc_d    = exc_q;
    stall    = 1'b0;
    md_start = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (x_q.md_status != STATUS_NONE) begin
          md_start = 1'b1;
          stall    = 1'b1;
          wd_d     = '0;
          state_d  = MD_BUSY;
        end
      end
      MD_BUSY: begin
        stall = 1'b1;
        if (md_ready) begin
          exc_d   = md_exc;
          state_d = MD_DONE;
        end else if (wd_q == WD_LAST) begin
          exc_d   = 1'b1;
          state_d = MD_DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Stall holds X and beats flush.
  always_comb begin
    if (stall) begin
      x_d = x_q;
    end else if (x_flush) begin
      x_d = '0;
    end else begin
      x_d = x_dec;
    end
  end

  // Word entering M: overflow and mult/div exception reroute to rstatus;
  // the two are exclusive because ovf_status and md_status never coexist.
  always_comb begin
    m_d.ram_we = x_q.ram_we;
    m_d.reg_we = x_q.reg_we;
    m_d.rd     = x_q.rd;
    m_d.wb_sel = x_q.wb_sel;
    m_d.status = STATUS_NONE;
    if (x_alu_ovf && (x_q.ovf_status != STATUS_NONE)) begin
      m_d.reg_we = 1'b1;
      m_d.rd     = REG_W'(STATUS_REG);
      m_d.wb_sel = WB_SEL_STATUS;
      m_d.status = x_q.ovf_status;
    end
    if ((state_q == MD_DONE) && exc_q && (x_q.md_status != STATUS_NONE)) begin
      m_d.reg_we = 1'b1;
      m_d.rd     = REG_W'(STATUS_REG);
      m_d.wb_sel = WB_SEL_STATUS;
      m_d.status = x_q.md_status;
    end
    if (stall) begin
      m_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
      state_q <= MD_IDLE;
      wd_q    <= '0;
      exc_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      m_q     <= m_d;
      w_q     <= '{reg_we: m_q.reg_we, rd: m_q.rd, wb_sel: m_q.wb_sel, status: m_q.status};
      state_q <= state_d;
      wd_q    <= wd_d;
      exc_q   <= exc_d;
    end
  end

  assign x_alu_op  = x_q.alu_op;
  assign x_alu_imm = x_q.alu_imm;
  assign m_ram_we  = m_q.ram_we;
  assign w_reg_we  = w_q.reg_we;
  assign w_rd      = w_q.rd;
  assign w_wb_sel  = w_q.wb_sel;
  assign w_status  = w_q.status;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
module tb_pipe_ctrl_unit;
  import pipe_ctrl_unit_pkg::*;

  localparam int TO = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       d_valid = 1'b0;
  logic [4:0] d_opcode = '0;
  logic [4:0] d_alu_op = '0;
  logic [4:0] d_rd = '0;
  logic       x_flush = 1'b0;
  logic       x_alu_ovf = 1'b0;
  logic       md_ready = 1'b0;
  logic       md_exc = 1'b0;
  logic       stall, md_start, x_alu_imm, m_ram_we, w_reg_we;
  logic [4:0] x_alu_op, w_rd;
  logic [1:0] w_wb_sel;
  logic [2:0] w_status;

  pipe_ctrl_unit #(
    .OP_W       (5),
    .REG_W      (5),
    .STATUS_REG (30),
    .LINK_REG   (31),
    .MD_TIMEOUT (TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .d_valid   (d_valid),
    .d_opcode  (d_opcode),
    .d_alu_op  (d_alu_op),
    .d_rd      (d_rd),
    .x_flush   (x_flush),
    .x_alu_ovf (x_alu_ovf),
    .md_ready  (md_ready),
    .md_exc    (md_exc),
    .stall     (stall),
    .md_start  (md_start),
    .x_alu_op  (x_alu_op),
    .x_alu_imm (x_alu_imm),
    .m_ram_we  (m_ram_we),
    .w_reg_we  (w_reg_we),
    .w_rd      (w_rd),
    .w_wb_sel  (w_wb_sel),
    .w_status  (w_status)
  );

  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;
  int stall_cnt = 0;
  int start_cnt = 0;
  int md_delay = 0;
  logic md_exc_cfg = 1'b0;
  logic ovf_pending = 1'b0;
  int flush_mode = 0;
  logic [9:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write-back monitor: every regfile write must match the next expected one.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        if (stall === 1'b1) stall_cnt++;
        if (md_start === 1'b1) start_cnt++;
        if (w_reg_we !== 1'b0) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL wb_unexpected: got rd=%0d sel=%0d st=%0d expected no write",
                     w_rd, w_wb_sel, w_status);
          end else begin
            e = exp_q.pop_front();
            if ({w_rd, w_wb_sel, w_status} !== e) begin
              tests_failed++;
              $display("FAIL wb_word: got rd=%0d sel=%0d st=%0d expected rd=%0d sel=%0d st=%0d",
                       w_rd, w_wb_sel, w_status, e[9:5], e[4:3], e[2:0]);
            end
          end
        end
      end
    end
  end

  // Flush driver: decided at negedge for the coming edge.
  initial begin
    forever begin
      @(negedge clock);
      x_flush = (flush_mode == 1) || ((flush_mode == 2) && (stall === 1'b1));
    end
  end

  // Mult/div unit model: result md_delay BUSY cycles after md_start (0 = never).
  initial begin
    forever begin
      @(negedge clock);
      if (md_start === 1'b1 && md_delay > 0) begin
        @(posedge clock);
        repeat (md_delay - 1) @(posedge clock);
        #1;
        md_ready = 1'b1;
        md_exc   = md_exc_cfg;
        @(posedge clock);
        #1;
        md_ready = 1'b0;
        md_exc   = 1'b0;
      end
    end
  end

  // Present one D instruction and return #1 after the edge that captures it.
  task automatic send(input logic v, input logic [4:0] op, input logic [4:0] alu,
                      input logic [4:0] rd, input logic ovf, input int fmode,
                      input logic push, input logic [9:0] exp);
    logic ok;
    ok = 1'b0;
    d_valid    = v;
    d_opcode   = op;
    d_alu_op   = alu;
    d_rd       = rd;
    x_alu_ovf  = ovf_pending;
    flush_mode = fmode;
    if (push) exp_q.push_back(exp);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (stall === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("stall_bound", 32'(ok), 32'd1);
    @(posedge clock);
    #1;
    ovf_pending = ovf;
    flush_mode  = 0;
  endtask

  task automatic ins(input logic [4:0] op, input logic [4:0] alu, input logic [4:0] rd,
                     input logic ovf, input logic push, input logic [9:0] exp);
    send(1'b1, op, alu, rd, ovf, 0, push, exp);
  endtask

  task automatic bub(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 0, 1'b0, 10'd0);
  endtask

  initial begin
    int s0, m0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outputs", {stall, md_start, x_alu_imm, m_ram_we, w_reg_we, w_rd, w_wb_sel, w_status}, 0);
    chk("reset_x_alu_op", x_alu_op, 0);
    reset = 1'b0;

    // addi latency
    ins(OPC_ADDI, 5'd0, 5'd3, 1'b0, 1'b1, {5'd3, 2'd0, 3'd0});
    chk("addi_x_imm", x_alu_imm, 1);
    bub(1);
    chk("addi_w_not_early", w_reg_we, 0);
    bub(1);
    chk("addi_w_latency", {w_reg_we, w_rd, w_wb_sel}, {1'b1, 5'd3, 2'd0});

    // sw/lw/jal/R/setx/undecoded
    ins(OPC_SW, 5'd0, 5'd5, 1'b0, 1'b0, 10'd0);
    chk("sw_x_imm", x_alu_imm, 1);
    chk("m_ram_we_before_sw", m_ram_we, 0);
    ins(OPC_LW, 5'd0, 5'd7, 1'b0, 1'b1, {5'd7, 2'd1, 3'd0});
    chk("sw_m_ram_we", m_ram_we, 1);
    chk("lw_x_imm", x_alu_imm, 1);
    ins(OPC_JAL, 5'd0, 5'd2, 1'b0, 1'b1, {5'd31, 2'd2, 3'd0});
    chk("lw_m_ram_we", m_ram_we, 0);
    chk("jal_x_imm", x_alu_imm, 0);
    ins(OPC_R, ALU_SUB, 5'd4, 1'b0, 1'b1, {5'd4, 2'd0, 3'd0});
    chk("sub_x_alu_op", x_alu_op, 5'd1);
    ins(OPC_SETX, 5'd3, 5'd9, 1'b0, 1'b1, {5'd30, 2'd0, 3'd0});
    chk("setx_x_alu_op", x_alu_op, 5'd0);
    ins(5'b01111, 5'd0, 5'd6, 1'b0, 1'b0, 10'd0);
    ins(OPC_BNE, 5'd1, 5'd6, 1'b0, 1'b0, 10'd0);
    ins(OPC_R, 5'b00010, 5'd12, 1'b0, 1'b1, {5'd12, 2'd0, 3'd0});
    bub(3);

    // mul, md_ready in 5th BUSY cycle
    md_delay = 5; md_exc_cfg = 1'b0;
    s0 = stall_cnt; m0 = start_cnt;
    ins(OPC_R, ALU_MUL, 5'd8, 1'b0, 1'b1, {5'd8, 2'd0, 3'd0});
    ins(OPC_ADDI, 5'd0, 5'd9, 1'b0, 1'b1, {5'd9, 2'd0, 3'd0});
    chk("mul_stall_cycles", stall_cnt - s0, 6);
    chk("mul_start_pulses", start_cnt - m0, 1);
    bub(3);

    // mul with exception
    md_exc_cfg = 1'b1;
    ins(OPC_R, ALU_MUL, 5'd8, 1'b0, 1'b1, {5'd30, 2'd3, 3'd4});
    bub(4);
    md_exc_cfg = 1'b0;

    // div watchdog timeout
    md_delay = 0;
    s0 = stall_cnt; m0 = start_cnt;
    ins(OPC_R, ALU_DIV, 5'd10, 1'b0, 1'b1, {5'd30, 2'd3, 3'd5});
    bub(1);
    chk("div_timeout_stall", stall_cnt - s0, TO + 1);
    bub(4);
    chk("div_single_start", start_cnt - m0, 1);

    // back-to-back mul
    md_delay = 2;
    s0 = stall_cnt; m0 = start_cnt;
    ins(OPC_R, ALU_MUL, 5'd11, 1'b0, 1'b1, {5'd11, 2'd0, 3'd0});
    ins(OPC_R, ALU_MUL, 5'd12, 1'b0, 1'b1, {5'd12, 2'd0, 3'd0});
    bub(1);
    chk("b2b_starts", start_cnt - m0, 2);
    chk("b2b_stall_cycles", stall_cnt - s0, 6);
    bub(3);

    // overflow rerouting
    ins(OPC_R, ALU_ADD, 5'd4, 1'b1, 1'b1, {5'd30, 2'd3, 3'd1});
    ins(OPC_R, ALU_SUB, 5'd5, 1'b1, 1'b1, {5'd30, 2'd3, 3'd3});
    ins(OPC_ADDI, 5'd0, 5'd6, 1'b1, 1'b1, {5'd30, 2'd3, 3'd2});
    ins(OPC_LW, 5'd0, 5'd7, 1'b1, 1'b1, {5'd7, 2'd1, 3'd0});
    ins(OPC_R, 5'b00010, 5'd13, 1'b1, 1'b1, {5'd13, 2'd0, 3'd0});
    bub(4);

    // flush with no stall kills D
    ins(OPC_J, 5'd0, 5'd0, 1'b0, 1'b0, 10'd0);
    send(1'b1, OPC_ADDI, 5'd0, 5'd13, 1'b0, 1, 1'b0, 10'd0);
    ins(OPC_ADDI, 5'd0, 5'd14, 1'b0, 1'b1, {5'd14, 2'd0, 3'd0});
    bub(3);

    // flush only while stalled has no effect
    md_delay = 3;
    ins(OPC_R, ALU_MUL, 5'd15, 1'b0, 1'b1, {5'd15, 2'd0, 3'd0});
    send(1'b1, OPC_ADDI, 5'd0, 5'd16, 1'b0, 2, 1'b1, {5'd16, 2'd0, 3'd0});
    bub(4);
    chk("queue_drained", exp_q.size(), 0);

    // reset during BUSY aborts the op
    md_delay = 0;
    ins(OPC_R, ALU_DIV, 5'd17, 1'b0, 1'b0, 10'd0);
    d_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("busy_stall", stall, 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset_abort", {stall, md_start, x_alu_op, w_reg_we}, 0);
    @(posedge clock);
    #1;
    chk("idle_after_abort", {stall, md_start}, 0);
    ins(OPC_ADDI, 5'd0, 5'd18, 1'b0, 1'b1, {5'd18, 2'd0, 3'd0});
    bub(4);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
